cordic_vectoring_prerotate: RTL
===============================

# cordic_vectoring_prerotate

Input-conditioning stage directly upstream of the 8-stage CORDIC vectoring pipeline. It accepts signed Cartesian samples over a valid/ready handshake and folds them into the right half-plane (x ≥ 0), where the ±45°-first iteration sequence converges. It emits the conditioned (x, y) pair with the base angle that the downstream angle output must be offset by. A 2-entry output buffer decouples the producer from the pipeline feeder.

## Interface
- WIDTH, 32, data width of x/y; two's complement.
- TAG_W, 8, width of the wrapping sequence tag.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a sample.
- in_ready  out  1  block accepts a sample this cycle.
- in_x, in_y  in  WIDTH  signed input vector.
- out_valid  out  1  head of buffer holds a result.
- out_ready  in  1  consumer takes the head this cycle.
- out_x, out_y  out  WIDTH  signed conditioned vector, out_x ≥ 0.
- out_base_angle  out  32  signed degrees × 1e6: 0, +90_000000 or −90_000000.
- out_zero  out  1  input was (0,0); angle is undefined.
- out_tag  out  TAG_W  sequence number of the sample.

## Operation
- Accept on in_valid && in_ready. Result is written into the buffer on the same edge.
- Fold rule, evaluated on the accepted sample:
  - x ≥ 0: x' = x, y' = y, base = 0.
  - x < 0, y ≥ 0: x' = y, y' = −x, base = +90_000000.
  - x < 0, y < 0: x' = −y, y' = x, base = −90_000000.
- Negation saturates: −(−2^(WIDTH−1)) yields 2^(WIDTH−1)−1. No other saturation.
- out_zero = (in_x == 0 && in_y == 0). The fold then takes the x ≥ 0 branch with base 0.
- Tag counter: starts at 0 after reset and increments by 1 per accepted sample. Wraps from 2^TAG_W−1 to 0. The accepted sample carries the pre-increment value.
- Buffer: 2 entries, FIFO order, 1-bit read and write pointers with wrap, count 0..2.
  - out_valid = (count != 0).
  - in_ready = (count < 2).
  - in_ready is a function of registered count only and never depends on in_valid or out_ready.
- Simultaneous events:
  - Push and pop at count 1: count stays 1, and the head advances to the new entry.
  - Push and pop at count 0 cannot occur because out_valid = 0.
  - At count 2, in_ready = 0. A pop alone frees one slot, and in_ready rises in the following cycle.
- Output data holds stable while out_valid && !out_ready.

## Timing
- Latency: a sample accepted at edge N is visible at the output after edge N (out_valid high in cycle N+1) if the buffer was empty.
- Throughput: 1 sample/cycle sustained while out_ready is held high.
- Reset, asserted asynchronously at any time including mid-transfer:
  - Count, pointers and tag clear to 0.
  - out_valid = 0 and in_ready = 0 while reset is low.
  - out_x, out_y, out_base_angle, out_zero and out_tag read 0.
  - Buffered samples are discarded.
- in_ready rises in the first cycle after reset deasserts.

## Configuration
- CORDIC_PRESCALE_EN defined: after folding, x' and y' are arithmetically shifted right by 1 (floor) before buffering. This gives one bit of headroom for the ≈1.647 CORDIC gain. out_base_angle is unaffected.
- CORDIC_PRESCALE_EN undefined: x' and y' are buffered unshifted. The producer guarantees |x|,|y| < 2^(WIDTH−2).

## Structure
- Shared package cordic_pkg holds:
  - ANGLE_90 = 90_000000 and the angle scale constant (1e6 per degree).
  - The fold-case enum {FOLD_NONE, FOLD_POS90, FOLD_NEG90}.
  - The default WIDTH.
- The downstream vectoring stages import the same angle constants from cordic_pkg.
- One sub-module, cordic_skid_fifo: a 2-entry buffer parameterised on payload width that owns count and pointers. The fold logic stays in the top module.

## Test plan
- in = (−3_000, 4_000), out_ready = 1 → out = (4_000, 3_000), base = +90_000000, tag 0, out_valid high in the next cycle.
- in = (−5, −7) then (6, −2) back-to-back → outputs (7, −5, −90_000000, tag 0) then (6, −2, 0, tag 1) in consecutive cycles.
- in_x = −2^31, in_y = −1 → out_x = 1, out_y = −2^31, base −90_000000, no wrap.
- in = (0, 0) → out_zero = 1, out = (0, 0), base 0.
- Flow control:
  - Hold out_ready = 0 and push 3 samples → only 2 accepted, in_ready = 0 after the second.
  - Raise out_ready for one cycle → the first sample pops, and in_ready = 1 in the next cycle.
  - The third sample then enters and ordering is preserved.
- Reset and tag wrap:
  - Drive reset low with 2 entries buffered → out_valid drops immediately, and the outputs read 0 after release.
  - Push 257 samples → tags read 0..255, 0.
  - With CORDIC_PRESCALE_EN defined, (−3, 5) → out = (2, 1).

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types: angle scaling, fold cases and default data width.
// Imported by the pre-rotation stage and the downstream vectoring stages.
package cordic_pkg;

    localparam int unsigned CORDIC_WIDTH = 32;

    // Angles are signed degrees scaled by 1e6.
    localparam int                 ANGLE_SCALE = 1_000_000;
    localparam logic signed [31:0] ANGLE_90    = 32'(90 * ANGLE_SCALE);

    typedef enum logic [1:0] {
        FOLD_NONE,
        FOLD_POS90,
        FOLD_NEG90
    } fold_e;

endpackage

// File: rtl/cordic_skid_fifo.sv
// Two-entry FIFO between the fold logic and the pipeline feeder; owns count and pointers.
// push_ready depends only on registered state and stays low until the first edge after reset.
module cordic_skid_fifo #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data
);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic              init_q;
    logic [DATA_W-1:0] mem_q [2];
    logic              do_push, do_pop;

    assign pop_valid  = (count_q != 2'd0);
    assign push_ready = init_q && (count_q != 2'd2);
    assign do_push    = push && push_ready;
    assign do_pop     = pop && pop_valid;
    assign pop_data   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            init_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            init_q  <= 1'b1;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: rtl/cordic_vectoring_prerotate.sv
// Folds signed (x, y) samples into the right half-plane ahead of the CORDIC vectoring pipeline.
// Optional CORDIC_PRESCALE_EN halves the folded vector to leave headroom for the CORDIC gain.
module cordic_vectoring_prerotate
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = CORDIC_WIDTH,
    parameter int unsigned TAG_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [31:0]      out_base_angle,
    output logic                    out_zero,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int unsigned PAYLOAD_W = 2 * WIDTH + 2 + 1 + TAG_W;
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
        return (v == MIN_VAL) ? MAX_VAL : -v;
    endfunction

    fold_e                   fold_case;
    logic signed [WIDTH-1:0] fold_x, fold_y;
    logic signed [WIDTH-1:0] cond_x, cond_y;
    logic                    is_zero;
    logic [TAG_W-1:0]        tag_q;
    logic [PAYLOAD_W-1:0]    push_data, pop_data;

    logic signed [WIDTH-1:0] head_x, head_y;
    logic [1:0]              head_case;
    logic                    head_zero;
    logic [TAG_W-1:0]        head_tag;

    // (0, 0) has a clear sign bit, so it naturally takes the no-fold branch.
    always_comb begin
        fold_case = FOLD_NONE;
        fold_x    = in_x;
        fold_y    = in_y;
        if (in_x[WIDTH-1]) begin
            if (!in_y[WIDTH-1]) begin
                fold_case = FOLD_POS90;
                fold_x    = in_y;
                fold_y    = sat_neg(in_x);
            end else begin
                fold_case = FOLD_NEG90;
                fold_x    = sat_neg(in_y);
                fold_y    = in_x;
            end
        end
    end

`ifdef CORDIC_PRESCALE_EN
    assign cond_x = fold_x >>> 1;
    assign cond_y = fold_y >>> 1;
`else
    assign cond_x = fold_x;
    assign cond_y = fold_y;
`endif

    assign is_zero   = (in_x == '0) && (in_y == '0);
    assign push_data = {cond_x, cond_y, fold_case, is_zero, tag_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_q <= '0;
        end else if (in_valid && in_ready) begin
            tag_q <= tag_q + TAG_W'(1);
        end
    end

    cordic_skid_fifo #(
        .DATA_W (PAYLOAD_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (in_valid),
        .push_data  (push_data),
        .push_ready (in_ready),
        .pop        (out_ready),
        .pop_valid  (out_valid),
        .pop_data   (pop_data)
    );

    assign {head_x, head_y, head_case, head_zero, head_tag} = pop_data;

    // Outputs read zero whenever the buffer is empty, including during and right after reset.
    always_comb begin
        out_x          = '0;
        out_y          = '0;
        out_base_angle = '0;
        out_zero       = 1'b0;
        out_tag        = '0;
        if (out_valid) begin
            out_x    = head_x;
            out_y    = head_y;
            out_zero = head_zero;
            out_tag  = head_tag;
            case (head_case)
                FOLD_POS90: out_base_angle = ANGLE_90;
                FOLD_NEG90: out_base_angle = -ANGLE_90;
                default:    out_base_angle = '0;
            endcase
        end
    end

endmodule
